// File: rtl/serial_rca.sv
// -----------------------------------------------------------------------------
// serial_rca -- digit-serial ripple-carry adder
//
// Adds two WIDTH-bit operands DIGIT bits per clock through one narrow adder
// slice. The carry between digits is held in a register. A start/busy/done
// handshake sequences the operation. The result is bit-identical to a
// combinational WIDTH-bit ripple-carry adder:
//   s = (a + b + c_in) mod 2^WIDTH, c_out = bit WIDTH of that sum.
//
// Parameters
//   WIDTH  operand/sum width; must be an integer multiple of DIGIT
//   DIGIT  bits added per clock, 1 <= DIGIT <= WIDTH
//   N = WIDTH/DIGIT digits per operation; latency start -> done is N cycles
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle (also in the done cycle)
//   a, b   in   operands, captured on the accepting edge
//   c_in   in   carry into bit 0, captured on the accepting edge
//   sub    in   subtract mode (only when SERIAL_RCA_SUB_EN is defined)
//   busy   out  operation in progress
//   done   out  one-cycle pulse when s/c_out update
//   s      out  sum, held between operations
//   c_out  out  carry out of bit WIDTH-1, held between operations
//
// Build option
//   SERIAL_RCA_SUB_EN : adds the 'sub' port. With sub=1 at capture, B is
//   inverted and the carry-in is forced to 1, so s = (a - b) mod 2^WIDTH
//   and c_out=1 means "no borrow"; c_in is ignored in that case.
// -----------------------------------------------------------------------------
module serial_rca #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int N  = WIDTH / DIGIT;
  // Counter is at least one bit even when a single digit covers the operand.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // State registers
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_c_out;

  // Next-state values
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_carry_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_s_nxt;
  logic             w_c_out_nxt;

  // Datapath helpers
  logic [DIGIT:0]   w_digit;
  logic [WIDTH-1:0] w_a_shr;
  logic [WIDTH-1:0] w_b_shr;
  logic [WIDTH-1:0] w_sum_shr;
  logic [WIDTH-1:0] w_b_cap;
  logic             w_cin_cap;

  // Operand B and carry-in as they are captured on an accepted start.
`ifdef SERIAL_RCA_SUB_EN
  // Two's-complement subtract: a + ~b + 1.
  assign w_b_cap   = sub ? ~b : b;
  assign w_cin_cap = sub ? 1'b1 : c_in;
`else
  assign w_b_cap   = b;
  assign w_cin_cap = c_in;
`endif

  // The single shared DIGIT-bit adder slice; bit DIGIT is the digit carry-out.
  assign w_digit = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                 + (DIGIT+1)'(r_carry);

  // Shift paths. With one digit per operand there is nothing left to shift,
  // and the part-selects below would be reversed, so that case is separate.
  if (DIGIT == WIDTH) begin : g_single_digit
    assign w_a_shr   = '0;
    assign w_b_shr   = '0;
    assign w_sum_shr = w_digit[DIGIT-1:0];
  end else begin : g_multi_digit
    assign w_a_shr   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
    assign w_b_shr   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    // New digit enters at the top; after N digits digit 0 sits at the bottom.
    assign w_sum_shr = {w_digit[DIGIT-1:0], r_sum[WIDTH-1:DIGIT]};
  end

  // FSM and datapath next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sum_nxt   = r_sum;
    w_carry_nxt = r_carry;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_s_nxt     = r_s;
    w_c_out_nxt = r_c_out;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_a_nxt     = a;
          w_b_nxt     = w_b_cap;
          w_carry_nxt = w_cin_cap;
          w_sum_nxt   = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end

      ST_RUN: begin
        // start is deliberately not looked at here: the operation in
        // flight cannot be disturbed or restarted.
        w_a_nxt     = w_a_shr;
        w_b_nxt     = w_b_shr;
        w_sum_nxt   = w_sum_shr;
        w_carry_nxt = w_digit[DIGIT];
        if (r_cnt == LAST_DIGIT) begin
          // Only here do the visible outputs change.
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_s_nxt     = w_sum_shr;
          w_c_out_nxt = w_digit[DIGIT];
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register bank with asynchronous clear; a reset mid-operation
  // discards the partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_c_out <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_sum   <= w_sum_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_s     <= w_s_nxt;
      r_c_out <= w_c_out_nxt;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign s     = r_s;
  assign c_out = r_c_out;

endmodule
